// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller feeding a 74HC595 driver.
// Optional leading-zero blanking is compiled in with `define SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_FREQ = 1_000,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_data,
  input  logic [7:0]  disp_dp,
  input  logic [7:0]  disp_en,
  input  logic        load,
  output logic [15:0] data,
  output logic        chip_en,
  output logic        frame_start,
  output logic        pending
);

  localparam int DIV = CLK_FREQ / SCAN_FREQ;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  logic [31:0] pend_data;
  logic [7:0]  pend_dp;
  logic [7:0]  pend_en;

  logic [31:0] act_data;
  logic [7:0]  act_dp;
  logic [7:0]  act_en;
  logic [7:0]  act_blank;

  logic        slot_end;
  logic        frame_end;
  logic [7:0]  lz_mask;
  logic [3:0]  cur_nib;
  logic [6:0]  dec7;
  logic        show;
  logic [7:0]  seg_w;
  logic [7:0]  sel_w;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == 3'd7);

  // Blank mask is derived from the pending frame so it travels with it into the active buffer.
  always_comb begin
    lz_mask = '0;
`ifdef SEG7_LZ_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = 7; i >= 1; i--) begin
        if (pend_en[i] && ((pend_data[4*i +: 4] != 4'h0) || pend_dp[i]))
          lead = 1'b0;
        lz_mask[i] = lead;
      end
    end
`endif
  end

  assign cur_nib = act_data[{idx, 2'b00} +: 4];

  // Active-low gfedcba patterns.
  always_comb begin
    dec7 = 7'h7F;
    case (cur_nib)
      4'h0: dec7 = 7'h40;
      4'h1: dec7 = 7'h79;
      4'h2: dec7 = 7'h24;
      4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;
      4'h5: dec7 = 7'h12;
      4'h6: dec7 = 7'h02;
      4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;
      4'h9: dec7 = 7'h10;
      4'hA: dec7 = 7'h08;
      4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46;
      4'hD: dec7 = 7'h21;
      4'hE: dec7 = 7'h06;
      4'hF: dec7 = 7'h0E;
      default: dec7 = 7'h7F;
    endcase
  end

  always_comb begin
    show  = act_en[idx] & ~act_blank[idx];
    seg_w = 8'hFF;
    sel_w = 8'h00;
    if (show) begin
      seg_w = {~act_dp[idx], dec7};
      sel_w = 8'b1 << idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 3'd0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pending     <= 1'b0;
      act_data    <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      act_blank   <= '0;
      data        <= 16'hFF00;
      chip_en     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      chip_en <= 1'b1;

      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (frame_end && pending) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_en    <= pend_en;
        act_blank <= lz_mask;
      end

      // A load on the transfer cycle wins the pending flag; the transfer above used the old contents.
      if (load) begin
        pend_data <= disp_data;
        pend_dp   <= disp_dp;
        pend_en   <= disp_en;
        pending   <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end

      if (cnt == '0)
        data <= {seg_w, sel_w};
      frame_start <= (cnt == '0) && (idx == 3'd0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIV=10) using a frame-level reference model.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 10;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] disp_data;
  logic [7:0]  disp_dp;
  logic [7:0]  disp_en;
  logic        load;
  logic [15:0] data;
  logic        chip_en;
  logic        frame_start;
  logic        pending;

  int total = 0;
  int bad   = 0;

  seg7_scan_ctrl #(.CLK_FREQ(1000), .SCAN_FREQ(100), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .disp_data(disp_data), .disp_dp(disp_dp),
    .disp_en(disp_en), .load(load), .data(data), .chip_en(chip_en),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: m_n counts edges since reset release; slot/frame position is arithmetic on it.
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          m_n;
  logic        m_pv;
  logic [31:0] m_pd;
  logic [7:0]  m_pdp, m_pen;
  logic [31:0] m_ad;
  logic [7:0]  m_adp, m_aen, m_ablank;
  logic [15:0] m_data;
  logic        m_fs, m_ce;
  logic [15:0] exp_q[$];

  function automatic logic [7:0] m_lz(logic [31:0] dd, logic [7:0] dp, logic [7:0] en);
    logic [7:0] mask;
    mask = '0;
`ifdef SEG7_LZ_BLANK_EN
    for (int d = 7; d >= 1; d--) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int j = d; j <= 7; j++)
        if (en[j] && (dd[j*4 +: 4] != 4'h0 || dp[j])) all_zero = 1'b0;
      mask[d] = all_zero;
    end
`endif
    return mask;
  endfunction

  function automatic logic [15:0] m_word(int d);
    logic [7:0] seg;
    if (!m_aen[d] || m_ablank[d]) return 16'hFF00;
    seg = seg_tab[m_ad[d*4 +: 4]];
    return {~m_adp[d], seg[6:0], 8'(1 << d)};
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_n = 0; m_pv = 0; m_pd = '0; m_pdp = '0; m_pen = '0;
      m_ad = '0; m_adp = '0; m_aen = '0; m_ablank = '0;
      m_data = 16'hFF00; m_fs = 0; m_ce = 0;
    end else begin
      m_n++;
      m_ce = 1'b1;
      m_fs = ((m_n - 1) % FRAME == 0);
      if ((m_n - 1) % DIV == 0) m_data = m_word(((m_n - 1) / DIV) % 8);
      if (m_n % FRAME == 0 && m_pv) begin
        m_ad = m_pd; m_adp = m_pdp; m_aen = m_pen;
        m_ablank = m_lz(m_pd, m_pdp, m_pen);
        m_pv = 1'b0;
      end
      if (load) begin
        m_pd = disp_data; m_pdp = disp_dp; m_pen = disp_en; m_pv = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go_to(int target);
    for (int i = 0; i < FRAME && (m_n % FRAME) != target; i++) tick();
  endtask

  task automatic do_load(logic [31:0] d, logic [7:0] dp, logic [7:0] en);
    disp_data = d; disp_dp = dp; disp_en = en; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; disp_data = '0; disp_dp = '0; disp_en = '0;
    repeat (3) begin
      tick();
      total++;
      if ({data, chip_en, frame_start, pending} !== {16'hFF00, 3'b000}) begin
        bad++; $display("FAIL reset_vals: got %h/%b/%b/%b want ff00/0/0/0", data, chip_en, frame_start, pending);
      end
    end
    reset = 1'b0;
    tick();
    total++;
    if (chip_en !== 1'b1 || frame_start !== 1'b1) begin
      bad++; $display("FAIL reset_release: got ce=%b fs=%b want ce=1 fs=1", chip_en, frame_start);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if ({data, chip_en, frame_start, pending} !== {m_data, m_ce, m_fs, m_pv}) begin
        bad++; $display("FAIL idle_scan: got %h/%b/%b/%b want %h/%b/%b/%b", data, chip_en, frame_start, pending, m_data, m_ce, m_fs, m_pv);
      end
    end
  endtask

  task automatic test_load_basic();
    int fs_cnt;
    go_to(35);
    do_load(32'h1234_ABCD, 8'h00, 8'hFF);
    total++;
    if (pending !== 1'b1 || data !== 16'hFF00) begin
      bad++; $display("FAIL load_pending: got p=%b data=%h want p=1 data=ff00", pending, data);
    end
    go_to(0);
    tick();
    total++;
    if (data !== 16'hA101 || pending !== 1'b0 || frame_start !== 1'b1) begin
      bad++; $display("FAIL basic_digit0: got %h p=%b fs=%b want a101 p=0 fs=1", data, pending, frame_start);
    end
    repeat (70) tick();
    total++;
    if (data !== 16'hF980) begin
      bad++; $display("FAIL basic_digit7: got %h want f980", data);
    end
    go_to(0);
    fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_start === 1'b1) fs_cnt++;
      total++;
      if ({data, frame_start, pending} !== {m_data, m_fs, m_pv}) begin
        bad++; $display("FAIL basic_scan: got %h/%b/%b want %h/%b/%b", data, frame_start, pending, m_data, m_fs, m_pv);
      end
    end
    total++;
    if (fs_cnt != 2) begin
      bad++; $display("FAIL frame_start_rate: got %0d pulses want 2", fs_cnt);
    end
  endtask

  task automatic test_mask();
    logic [15:0] exp_tab [8] = '{16'h8001, 16'hFF00, 16'h4004, 16'hFF00,
                                 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    go_to(35);
    do_load(32'h0000_0088, 8'h04, 8'b0000_0101);
    go_to(0);
    for (int d = 0; d < 8; d++) exp_q.push_back(exp_tab[d]);
    for (int d = 0; d < 8; d++) begin
      logic [15:0] e;
      tick();
      e = exp_q.pop_front();
      total++;
      if (data !== e) begin
        bad++; $display("FAIL mask_digit%0d: got %h want %h", d, data, e);
      end
      repeat (DIV - 1) tick();
    end
  endtask

  task automatic test_double_load();
    go_to(20);
    do_load(32'h1111_1111, 8'h00, 8'hFF);
    go_to(50);
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    go_to(0);
    tick();
    total++;
    if (data !== 16'hA401 || pending !== 1'b0) begin
      bad++; $display("FAIL last_load_wins: got %h p=%b want a401 p=0", data, pending);
    end
    go_to(30);
    do_load(32'h4444_4444, 8'h00, 8'hFF);
    go_to(FRAME - 1);
    do_load(32'h3333_3333, 8'h00, 8'hFF);
    total++;
    if (pending !== 1'b1) begin
      bad++; $display("FAIL load_on_transfer_pending: got %b want 1", pending);
    end
    tick();
    total++;
    if (data !== 16'h9901 || pending !== 1'b1) begin
      bad++; $display("FAIL load_on_transfer_old: got %h p=%b want 9901 p=1", data, pending);
    end
    go_to(0);
    tick();
    total++;
    if (data !== 16'hB001 || pending !== 1'b0) begin
      bad++; $display("FAIL load_on_transfer_new: got %h p=%b want b001 p=0", data, pending);
    end
  endtask

  task automatic test_reset_mid();
    go_to(20);
    do_load(32'h5555_5555, 8'hFF, 8'hFF);
    go_to(51);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({data, chip_en, frame_start, pending} !== {16'hFF00, 3'b000}) begin
      bad++; $display("FAIL mid_reset: got %h/%b/%b/%b want ff00/0/0/0", data, chip_en, frame_start, pending);
    end
    tick();
    total++;
    if (frame_start !== 1'b1 || chip_en !== 1'b1) begin
      bad++; $display("FAIL mid_reset_restart: got fs=%b ce=%b want 1/1", frame_start, chip_en);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total++;
      if ({data, frame_start, pending} !== {16'hFF00, m_fs, 1'b0}) begin
        bad++; $display("FAIL mid_reset_blank: got %h/%b/%b want ff00/%b/0", data, frame_start, pending, m_fs);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        disp_data = $urandom; disp_dp = 8'($urandom); disp_en = 8'($urandom);
        if ($urandom_range(0, 3) == 0) disp_data[31:16] = 16'h0000;
        load = 1'b1;
      end
      tick();
      load = 1'b0;
      total++;
      if ({data, chip_en, frame_start, pending} !== {m_data, m_ce, m_fs, m_pv}) begin
        bad++; $display("FAIL random_scan: n=%0d got %h/%b/%b/%b want %h/%b/%b/%b", m_n, data, chip_en, frame_start, pending, m_data, m_ce, m_fs, m_pv);
      end
    end
  endtask

  task automatic test_lz();
`ifdef SEG7_LZ_BLANK_EN
    logic [15:0] e1 [8] = '{16'h9201, 16'hC002, 16'h9904, 16'hFF00,
                            16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    logic [15:0] e2 [8] = '{16'hC001, 16'hFF00, 16'hFF00, 16'hFF00,
                            16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
`else
    logic [15:0] e1 [8] = '{16'h9201, 16'hC002, 16'h9904, 16'hC008,
                            16'hC010, 16'hC020, 16'hC040, 16'hC080};
    logic [15:0] e2 [8] = '{16'hC001, 16'hC002, 16'hC004, 16'hC008,
                            16'hC010, 16'hC020, 16'hC040, 16'hC080};
`endif
    go_to(35);
    do_load(32'h0000_0405, 8'h00, 8'hFF);
    go_to(0);
    for (int d = 0; d < 8; d++) begin
      tick();
      total++;
      if (data !== e1[d]) begin
        bad++; $display("FAIL zeros_a_digit%0d: got %h want %h", d, data, e1[d]);
      end
      repeat (DIV - 1) tick();
    end
    go_to(35);
    do_load(32'h0000_0000, 8'h00, 8'hFF);
    go_to(0);
    for (int d = 0; d < 8; d++) begin
      tick();
      total++;
      if (data !== e2[d] || data !== m_data) begin
        bad++; $display("FAIL zeros_b_digit%0d: got %h want %h", d, data, e2[d]);
      end
      repeat (DIV - 1) tick();
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0;
    disp_data = '0; disp_dp = '0; disp_en = '0;
    m_n = 0;
    test_reset();
    test_load_basic();
    test_mask();
    test_double_load();
    test_reset_mid();
    test_random();
    test_lz();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
